// File: rtl/counter_access_arbiter_if.sv
// rtl/counter_access_arbiter_if.sv - requester and counter-control signal bundle for counter_access_arbiter
interface counter_access_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] dir;
   logic [WIDTH-1:0]   ctr_count;
   logic               ctr_up;
   logic               ctr_down;
   logic [NUM_REQ-1:0] ack;
   logic               err;
   logic [WIDTH-1:0]   rsp_count;
   logic               busy;

   modport slave (
      input  req, dir, ctr_count,
      output ctr_up, ctr_down, ack, err, rsp_count, busy
   );

   modport master (
      output req, dir, ctr_count,
      input  ctr_up, ctr_down, ack, err, rsp_count, busy
   );
endinterface

// File: rtl/counter_access_arbiter.sv
// rtl/counter_access_arbiter.sv - round-robin arbiter sharing one up/down counter among requesters
module counter_access_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   counter_access_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   win_q;
   logic               sat_q;
   logic               ctr_up_q;
   logic               ctr_down_q;
   logic [NUM_REQ-1:0] ack_q;
   logic               err_q;
   logic [WIDTH-1:0]   rsp_count_q;
   logic               busy_q;

   logic [IDX_W-1:0]   win_d;
   logic               found_d;
   logic               sat_d;
   logic [IDX_W:0]     cand;

   // First requester at or above the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_REQ)) begin
            cand = cand - (IDX_W+1)'(NUM_REQ);
         end
         if (!found_d && bus.req[cand[IDX_W-1:0]]) begin
            found_d = 1'b1;
            win_d   = cand[IDX_W-1:0];
         end
      end
   end

   // Saturation uses the live count, so the counter's init value never matters here.
   assign sat_d = bus.dir[win_d] ? (bus.ctr_count == {WIDTH{1'b1}})
                                 : (bus.ctr_count == {WIDTH{1'b0}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         sat_q       <= 1'b0;
         ctr_up_q    <= 1'b0;
         ctr_down_q  <= 1'b0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         rsp_count_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  win_q      <= win_d;
                  sat_q      <= sat_d;
                  ctr_up_q   <= !sat_d && bus.dir[win_d];
                  ctr_down_q <= !sat_d && !bus.dir[win_d];
                  busy_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               ctr_up_q   <= 1'b0;
               ctr_down_q <= 1'b0;
               state_q    <= CAPTURE;
            end
            CAPTURE: begin
               rsp_count_q <= bus.ctr_count;
               ack_q       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
               err_q       <= sat_q;
               state_q     <= RESPOND;
            end
            RESPOND: begin
               ack_q   <= '0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               ptr_q   <= (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + IDX_W'(1);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ctr_up    = ctr_up_q;
   assign bus.ctr_down  = ctr_down_q;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.rsp_count = rsp_count_q;
   assign bus.busy      = busy_q;
endmodule

// File: doc/counter_access_arbiter.md
# counter_access_arbiter

Round-robin access controller that shares one `parameterized_counter` instance between `NUM_REQ` requesters. Each requester asks for a single increment or decrement through a req/ack handshake. The block drives the counter's `up`/`down` pins one cycle at a time, blocks overflow and underflow, and returns the post-operation count to the winning requester. It sits between the requesting agents and the counter, and is the only driver of the counter's control pins.

## Interface
- `WIDTH`, default 8: counter width; must equal the counter instance's `WIDTH`.
- `NUM_REQ`, default 4: number of requesters, 2..16.

- `clk`  in  1  clock, shared with the counter.
- `rst_n`  in  1  asynchronous, active-low reset. The same net resets the counter.
- `req`  in  NUM_REQ  per-requester request. Held high until that requester's `ack` is seen.
- `dir`  in  NUM_REQ  per-requester direction: 1 = increment, 0 = decrement. Held stable while `req` is high.
- `ctr_count`  in  WIDTH  current value from the counter's `count` output.
- `ctr_up`  out  1  to the counter's `up` pin.
- `ctr_down`  out  1  to the counter's `down` pin.
- `ack`  out  NUM_REQ  one-hot, single-cycle completion pulse.
- `err`  out  1  valid with `ack`. 1 = operation refused (saturation).
- `rsp_count`  out  WIDTH  valid with `ack`: counter value after the operation.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Outputs are registered. Reset values: `ctr_up`=0, `ctr_down`=0, `ack`=0, `err`=0, `rsp_count`=0, `busy`=0. Internal reset state: FSM=IDLE, round-robin pointer=0.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESPOND -> IDLE. There are no other transitions, except asynchronous reset to IDLE from any state.
- IDLE
  - If `req` is all zero, the FSM stays in IDLE.
  - Otherwise the winner is the first set bit searched from the pointer index upward, wrapping modulo `NUM_REQ`.
  - The block latches the winner index, its `dir`, and a saturation flag, then moves to ISSUE.
  - Saturation flag = (`dir`=1 and `ctr_count`=2^WIDTH-1) or (`dir`=0 and `ctr_count`=0).
- ISSUE
  - If not saturated: exactly one of `ctr_up`/`ctr_down` is high for this single cycle, according to the latched `dir`.
  - If saturated: both stay low.
  - `ctr_up` and `ctr_down` are never high together. Each is high for at most one cycle per grant.
- CAPTURE: `ctr_count` now reflects the update. It is registered into `rsp_count` at the end of this cycle.
- RESPOND
  - `ack[winner]`=1 and `err`=saturation flag for exactly one cycle.
  - The pointer is updated to (winner+1) mod `NUM_REQ`.
- Requesters with `req` high but not granted keep waiting. Their `req` is re-arbitrated in the next IDLE.
- The counter's count value wraps natively, but this block never lets that happen: an increment at all-ones or a decrement at zero is refused with `err`=1, and the count is unchanged.
- `rsp_count` holds its value between acks.
- Counter reset value is its `init_val`, not zero. Saturation checks use the live `ctr_count` and need no knowledge of `init_val`.
- Protocol violation (`req` dropped mid-operation): the operation still completes and `ack` still pulses. The block does not check `dir` stability.
- Asynchronous reset mid-operation:
  - All outputs go to their reset values immediately.
  - Any in-flight `ctr_up`/`ctr_down` pulse is cancelled. No `ack` is issued for the aborted request.
  - The pointer returns to 0.

## Timing
- Request sampled in IDLE at cycle N.
- Counter pulse in cycle N+1. Counter updates at the end of N+1.
- `ack`, `err` and `rsp_count` are valid in cycle N+3. IDLE is re-entered at N+4.
- Throughput: one operation per 4 cycles with back-to-back requests.
- `busy` is high in cycles N+1..N+3.
- A requester must drop `req` (or present a new `dir`) in the cycle after it sees `ack`. IDLE samples in N+4, so an already-acked request is never serviced twice if it is deasserted at N+4.
- Worst-case wait for any requester with continuous contention: `NUM_REQ` × 4 cycles.

## Test plan
- Reset with counter `init_val`=10. Requester 0 raises `req` with `dir`=1 -> `ctr_up` pulses for one cycle, `ack`=0001 three cycles after sampling, `err`=0, `rsp_count`=11, `busy` high for 3 cycles.
- Counter at 255 (WIDTH=8). Requester 2 requests increment -> no `ctr_up` pulse, `ack`=0100, `err`=1, `rsp_count`=255. Repeat at count 0 with a decrement -> `err`=1, `rsp_count`=0.
- All four requesters hold `req` continuously, all with `dir`=1, starting at count 0 -> grant order 0,1,2,3,0, with `rsp_count` 1,2,3,4,5 and acks spaced 4 cycles apart.
- Requesters 1 (up) and 3 (down) request together at count 50 with the pointer at 2 -> requester 3 is served first (`rsp_count`=49), then requester 1 (`rsp_count`=50). `ctr_up` and `ctr_down` are never high together.
- Assert `rst_n` low during ISSUE -> `ctr_up`/`ctr_down` drop immediately, no `ack` is issued, the counter returns to `init_val`. After release, the next request is served from pointer 0.
